data_mem_responder: RTL and testbench

- Responder side of the processor's data-memory interface. Serves load/store requests from the datapath: address is ALU result bits [2:0], write data is register-file data2.
- Adds a valid/ready request/response handshake and programmable wait states, so the core can later stall on memory instead of assuming single-cycle access.
- Holds the 8 x 16-bit data store itself.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_array.sv | 45 ++++
 rtl/data_mem_responder.sv | 172 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: state encoding,
// default widths and the data value returned for store responses.
package dmem_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;

   // Data value placed on rsp_rdata when the response belongs to a store.
   localparam int RSP_STORE_DATA = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// 2**ADDR_W x DATA_W register-array data store.
// Asynchronous clear to zero, single write port, combinational read.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] mem_d [DEPTH];

   // Next array contents: copy of current contents with the addressed word replaced on a write.
   always_comb begin
      mem_d = mem_q;
      if (we) begin
         mem_d[addr] = wdata;
      end else begin
         mem_d[addr] = mem_q[addr];
      end
   end

   // Array storage with asynchronous clear of every word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata = mem_q[addr];

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time over a
// valid/ready request channel, waits WAIT_CYCLES, performs the access
// and holds the response until the initiator takes it.
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_was_write,
   output logic              busy
);

   // Counter must hold WAIT_CYCLES; keep at least one bit when no wait states are used.
   localparam int              CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [DATA_W-1:0] STORE_RDATA = DATA_W'(RSP_STORE_DATA);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              was_write_q, was_write_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              busy_q, busy_d;

   // Access-port selection: latched fields from WAIT, or live request fields when there are no wait states.
   logic              access_s;
   logic              acc_write_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic [DATA_W-1:0] acc_wdata_s;
   logic [DATA_W-1:0] mem_rdata_s;

   dmem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (access_s & acc_write_s),
      .addr  (acc_addr_s),
      .wdata (acc_wdata_s),
      .rdata (mem_rdata_s)
   );

   // Next-state, request latching, access strobe and response data.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      was_write_d = was_write_q;
      access_s    = 1'b0;
      acc_write_s = wr_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               cnt_d   = CNT_LOAD;
               if (WAIT_CYCLES == 0) begin
                  access_s    = 1'b1;
                  acc_write_s = req_write;
                  acc_addr_s  = req_addr;
                  acc_wdata_s = req_wdata;
                  state_d     = RESP;
               end else begin
                  state_d = WAIT;
               end
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == CNT_ONE) begin
               access_s = 1'b1;
               cnt_d    = {CNT_W{1'b0}};
               state_d  = RESP;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
               state_d = WAIT;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               rdata_d = {DATA_W{1'b0}};
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase

      if (access_s) begin
         if (acc_write_s) begin
            rdata_d     = STORE_RDATA;
            was_write_d = 1'b1;
         end else begin
            rdata_d     = mem_rdata_s;
            was_write_d = 1'b0;
         end
      end else begin
         was_write_d = was_write_d;
      end
   end

   // Handshake/status outputs decoded from the next state so they come straight off flops.
   always_comb begin
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
      busy_d      = (state_d == WAIT) || (state_d == RESP);
   end

   // State, counter, latched request and registered outputs; reset drops any in-flight request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         wr_q        <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         rdata_q     <= {DATA_W{1'b0}};
         was_write_q <= 1'b0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         was_write_q <= was_write_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rdata_q;
   assign rsp_was_write = was_write_q;
   assign busy          = busy_q;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (2 wait states and 0 wait
// states) driven with directed and random transactions, checked against
// a plain array memory model and the cycle timing of the handshake.
module tb_data_mem_responder;

   localparam time PERIOD = 10;

   logic        clk;
   logic        rst_s;
   logic        req_valid_s     [2];
   logic        req_write_s     [2];
   logic [2:0]  req_addr_s      [2];
   logic [15:0] req_wdata_s     [2];
   logic        rsp_ready_s     [2];
   logic        req_ready_s     [2];
   logic        rsp_valid_s     [2];
   logic [15:0] rsp_rdata_s     [2];
   logic        rsp_was_write_s [2];
   logic        busy_s          [2];

   logic [15:0] mem_model [2][8];
   int          n_checks;
   int          n_errors;
   int          cur_dut;

   data_mem_responder #(.DATA_W(16), .ADDR_W(3), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk           (clk),
      .rst           (rst_s),
      .req_valid     (req_valid_s[0]),
      .req_ready     (req_ready_s[0]),
      .req_write     (req_write_s[0]),
      .req_addr      (req_addr_s[0]),
      .req_wdata     (req_wdata_s[0]),
      .rsp_valid     (rsp_valid_s[0]),
      .rsp_ready     (rsp_ready_s[0]),
      .rsp_rdata     (rsp_rdata_s[0]),
      .rsp_was_write (rsp_was_write_s[0]),
      .busy          (busy_s[0])
   );

   data_mem_responder #(.DATA_W(16), .ADDR_W(3), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk           (clk),
      .rst           (rst_s),
      .req_valid     (req_valid_s[1]),
      .req_ready     (req_ready_s[1]),
      .req_write     (req_write_s[1]),
      .req_addr      (req_addr_s[1]),
      .req_wdata     (req_wdata_s[1]),
      .rsp_valid     (rsp_valid_s[1]),
      .rsp_ready     (rsp_ready_s[1]),
      .rsp_rdata     (rsp_rdata_s[1]),
      .rsp_was_write (rsp_was_write_s[1]),
      .busy          (busy_s[1])
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #(PERIOD / 2) clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #(PERIOD * 20000);
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   function automatic int wait_of(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s (dut %0d) at %0t: got %0h expected %0h", tag, cur_dut, $time, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 8; a++) begin
            mem_model[d][a] = 16'h0000;
         end
      end
   endtask

   // One complete transaction: present, accept, wait states, optional
   // backpressure, handshake. Response becomes visible after the accept
   // edge plus WAIT_CYCLES further edges.
   task automatic do_txn(input int d, input bit wr, input logic [2:0] a, input logic [15:0] wd,
                         input int stall, input bit perturb, output time acc_t);
      logic [15:0] exp_rd;
      logic        exp_ww;
      cur_dut = d;
      @(negedge clk);
      req_valid_s[d] = 1'b1;
      req_write_s[d] = wr;
      req_addr_s[d]  = a;
      req_wdata_s[d] = wd;
      rsp_ready_s[d] = 1'b0;
      check_eq("req_ready_idle", {31'd0, req_ready_s[d]}, 32'd1);
      @(posedge clk);
      acc_t = $time;
      #1;
      if (perturb) begin
         req_write_s[d] = 1'($urandom);
         req_addr_s[d]  = 3'($urandom);
         req_wdata_s[d] = 16'($urandom);
      end else begin
         req_valid_s[d] = 1'b0;
      end
      if (wr) begin
         mem_model[d][a] = wd;
         exp_rd = 16'h0000;
         exp_ww = 1'b1;
      end else begin
         exp_rd = mem_model[d][a];
         exp_ww = 1'b0;
      end
      for (int k = 0; k < wait_of(d); k++) begin
         check_eq("wait_rsp_valid", {31'd0, rsp_valid_s[d]}, 32'd0);
         check_eq("wait_busy", {31'd0, busy_s[d]}, 32'd1);
         check_eq("wait_req_ready", {31'd0, req_ready_s[d]}, 32'd0);
         @(posedge clk);
         #1;
      end
      check_eq("rsp_valid", {31'd0, rsp_valid_s[d]}, 32'd1);
      check_eq("rsp_rdata", {16'd0, rsp_rdata_s[d]}, {16'd0, exp_rd});
      check_eq("rsp_was_write", {31'd0, rsp_was_write_s[d]}, {31'd0, exp_ww});
      check_eq("resp_busy", {31'd0, busy_s[d]}, 32'd1);
      check_eq("resp_req_ready", {31'd0, req_ready_s[d]}, 32'd0);
      for (int k = 0; k < stall; k++) begin
         @(posedge clk);
         #1;
         check_eq("stall_rsp_valid", {31'd0, rsp_valid_s[d]}, 32'd1);
         check_eq("stall_rsp_rdata", {16'd0, rsp_rdata_s[d]}, {16'd0, exp_rd});
         check_eq("stall_req_ready", {31'd0, req_ready_s[d]}, 32'd0);
      end
      rsp_ready_s[d] = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready_s[d] = 1'b0;
      req_valid_s[d] = 1'b0;
      check_eq("done_rsp_valid", {31'd0, rsp_valid_s[d]}, 32'd0);
      check_eq("done_rsp_rdata", {16'd0, rsp_rdata_s[d]}, 32'd0);
      check_eq("done_req_ready", {31'd0, req_ready_s[d]}, 32'd1);
      check_eq("done_busy", {31'd0, busy_s[d]}, 32'd0);
   endtask

   task automatic check_idle_outputs(input string tag);
      for (int d = 0; d < 2; d++) begin
         cur_dut = d;
         check_eq({tag, "_req_ready"}, {31'd0, req_ready_s[d]}, 32'd1);
         check_eq({tag, "_rsp_valid"}, {31'd0, rsp_valid_s[d]}, 32'd0);
         check_eq({tag, "_busy"}, {31'd0, busy_s[d]}, 32'd0);
         check_eq({tag, "_rsp_rdata"}, {16'd0, rsp_rdata_s[d]}, 32'd0);
         check_eq({tag, "_was_write"}, {31'd0, rsp_was_write_s[d]}, 32'd0);
      end
   endtask

   // Main stimulus sequence.
   initial begin
      time t0;
      time t1;
      n_checks = 0;
      n_errors = 0;
      cur_dut  = 0;
      for (int d = 0; d < 2; d++) begin
         req_valid_s[d] = 1'b0;
         req_write_s[d] = 1'b0;
         req_addr_s[d]  = 3'd0;
         req_wdata_s[d] = 16'h0000;
         rsp_ready_s[d] = 1'b0;
      end
      clear_model();

      // Reset held for three cycles; outputs idle throughout.
      rst_s = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check_idle_outputs("reset");
      end
      @(negedge clk);
      rst_s = 1'b1;

      // Every word reads back zero after reset.
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 8; a++) begin
            do_txn(d, 1'b0, 3'(a), 16'h0000, 0, 1'b0, t0);
         end
      end

      // Store then load, followed by a held-off load with an ignored request.
      do_txn(0, 1'b1, 3'd5, 16'hBEEF, 0, 1'b0, t0);
      do_txn(0, 1'b0, 3'd5, 16'h0000, 0, 1'b0, t0);
      do_txn(0, 1'b0, 3'd5, 16'h0000, 4, 1'b1, t0);

      // No wait states: back-to-back acceptances two cycles apart.
      do_txn(1, 1'b1, 3'd7, 16'h1234, 0, 1'b0, t0);
      do_txn(1, 1'b0, 3'd7, 16'h0000, 0, 1'b0, t1);
      cur_dut = 1;
      check_eq("b2b_spacing", 32'(t1 - t0), 32'(2 * PERIOD));

      // Request fields change after acceptance; latched values must be used.
      for (int d = 0; d < 2; d++) begin
         do_txn(d, 1'b1, 3'd3, 16'h5A5A, 1, 1'b1, t0);
         do_txn(d, 1'b0, 3'd3, 16'h0000, 0, 1'b1, t0);
      end

      // Reset during WAIT discards the store; memory returns to zero.
      cur_dut = 0;
      @(negedge clk);
      req_valid_s[0] = 1'b1;
      req_write_s[0] = 1'b1;
      req_addr_s[0]  = 3'd2;
      req_wdata_s[0] = 16'hAAAA;
      @(posedge clk);
      #1;
      req_valid_s[0] = 1'b0;
      check_eq("midop_busy", {31'd0, busy_s[0]}, 32'd1);
      @(negedge clk);
      rst_s = 1'b0;
      #1;
      check_idle_outputs("midop_reset");
      repeat (2) @(negedge clk);
      rst_s = 1'b1;
      clear_model();
      for (int d = 0; d < 2; d++) begin
         do_txn(d, 1'b0, 3'd2, 16'h0000, 0, 1'b0, t0);
         do_txn(d, 1'b0, 3'd5, 16'h0000, 0, 1'b0, t0);
      end

      // Random mix of loads and stores on both instances.
      for (int i = 0; i < 60; i++) begin
         do_txn(int'($urandom_range(1, 0)), 1'($urandom), 3'($urandom), 16'($urandom),
                int'($urandom_range(3, 0)), 1'($urandom), t0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_data_mem_responder
